// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside ID: tracks in-flight register writes and
// produces forward selects, load-use stalls, branch flush and freeze.
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_READY = 1,
    parameter int BR_FLUSH   = 1,
    parameter int CNT_W      = 16,
    localparam int FWSEL_W   = $clog2(FWD_STAGES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  rs,
    input  logic [REG_AW-1:0]  rt,
    input  logic               rs_used,
    input  logic               rt_used,
    input  logic               id_wreg,
    input  logic [REG_AW-1:0]  id_waddr,
    input  logic               id_load,
    input  logic               branch_taken,
    input  logic               mem_busy,
    output logic [FWSEL_W-1:0] fwda,
    output logic [FWSEL_W-1:0] fwdb,
    output logic               stall,
    output logic               pc_hold,
    output logic               flush,
    output logic               freeze,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int FC_W = 3;

    logic [FWD_STAGES-1:0] vld_q, vld_d;
    logic [FWD_STAGES-1:0] ld_q, ld_d;
    logic [REG_AW-1:0]     wa_q [FWD_STAGES];
    logic [REG_AW-1:0]     wa_d [FWD_STAGES];
    logic [FC_W-1:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0]      scnt_q, scnt_d;

    logic use_a, use_b;
    logic hit_a, hit_b;
    logic rdy_a, rdy_b;
    int   k_a, k_b;

    // Scan oldest to youngest so the nearest (smallest k) match wins.
    always_comb begin
        use_a = rs_used && (rs != '0);
        use_b = rt_used && (rt != '0);
        hit_a = 1'b0;
        hit_b = 1'b0;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        k_a   = 0;
        k_b   = 0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (use_a && vld_q[k] && (wa_q[k] == rs)) begin
                hit_a = 1'b1;
                rdy_a = !ld_q[k] || (k >= LOAD_READY);
                k_a   = k;
            end
            if (use_b && vld_q[k] && (wa_q[k] == rt)) begin
                hit_b = 1'b1;
                rdy_b = !ld_q[k] || (k >= LOAD_READY);
                k_b   = k;
            end
        end
        fwda = (hit_a && rdy_a) ? FWSEL_W'(FWD_STAGES - k_a) : '0;
        fwdb = (hit_b && rdy_b) ? FWSEL_W'(FWD_STAGES - k_b) : '0;
    end

    assign stall     = id_valid && ((hit_a && !rdy_a) || (hit_b && !rdy_b));
    assign freeze    = mem_busy;
    assign pc_hold   = stall || freeze;
    assign flush     = (fcnt_q != '0);
    assign stall_cnt = scnt_q;

    always_comb begin
        vld_d  = vld_q;
        ld_d   = ld_q;
        wa_d   = wa_q;
        fcnt_d = fcnt_q;
        scnt_d = scnt_q;
        if (!freeze) begin
            vld_d[0] = id_valid && id_wreg && !stall && !flush;
            wa_d[0]  = id_waddr;
            ld_d[0]  = id_load;
            for (int k = 1; k < FWD_STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                wa_d[k]  = wa_q[k-1];
                ld_d[k]  = ld_q[k-1];
            end
            if (branch_taken && id_valid && !stall && !flush) begin
                fcnt_d = FC_W'(BR_FLUSH);
            end else if (flush) begin
                fcnt_d = fcnt_q - 1'b1;
            end
            if (stall && (scnt_q != '1)) begin
                scnt_d = scnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            ld_q   <= '0;
            fcnt_q <= '0;
            scnt_q <= '0;
            for (int k = 0; k < FWD_STAGES; k++) begin
                wa_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            ld_q   <= ld_d;
            wa_q   <= wa_d;
            fcnt_q <= fcnt_d;
            scnt_q <= scnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard against an
// age-based model of issued register writes.
module tb_hazard_scoreboard;

    localparam int FWD = 3;
    localparam int LR  = 1;
    localparam int BF  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] rs = '0, rt = '0;
    logic       rs_used = 1'b0, rt_used = 1'b0;
    logic       id_wreg = 1'b0;
    logic [4:0] id_waddr = '0;
    logic       id_load = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_busy = 1'b0;
    logic [1:0] fwda, fwdb;
    logic       stall, pc_hold, flush, freeze;
    logic [15:0] stall_cnt;

    hazard_scoreboard #(
        .REG_AW(5), .FWD_STAGES(FWD), .LOAD_READY(LR),
        .BR_FLUSH(BF), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
        .id_wreg(id_wreg), .id_waddr(id_waddr), .id_load(id_load),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .fwda(fwda), .fwdb(fwdb), .stall(stall), .pc_hold(pc_hold),
        .flush(flush), .freeze(freeze), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: every accepted write is stamped with the advance count at
    // issue; its age in advances gives the stage it occupies.
    typedef struct {
        int         idx;
        logic [4:0] a;
        bit         ld;
    } wr_t;

    wr_t q[$];
    int  adv = 0;
    int  fl_left = 0;
    int  scnt = 0;

    task automatic model_reset();
        q.delete();
        adv = 0;
        fl_left = 0;
        scnt = 0;
    endtask

    task automatic lookup(input bit used, input logic [4:0] a,
                          output int sel, output bit nr);
        sel = 0;
        nr = 0;
        if (used && a != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                int age;
                age = adv - 1 - q[i].idx;
                if (age < FWD && q[i].a == a) begin
                    if (!q[i].ld || age >= LR) sel = FWD - age;
                    else nr = 1;
                    break;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [4:0] a, b,
                        input logic ua, ub, wr, input logic [4:0] wa,
                        input logic ld, br, busy);
        int  sa, sb;
        bit  na, nb, e_stall, e_flush;
        @(negedge clk);
        id_valid = v; rs = a; rt = b; rs_used = ua; rt_used = ub;
        id_wreg = wr; id_waddr = wa; id_load = ld;
        branch_taken = br; mem_busy = busy;
        #1;
        lookup(ua, a, sa, na);
        lookup(ub, b, sb, nb);
        e_stall = v && (na || nb);
        e_flush = fl_left > 0;
        check("fwda", 32'(fwda), 32'(sa));
        check("fwdb", 32'(fwdb), 32'(sb));
        check("stall", 32'(stall), 32'(e_stall));
        check("pc_hold", 32'(pc_hold), 32'(e_stall || busy));
        check("flush", 32'(flush), 32'(e_flush));
        check("freeze", 32'(freeze), 32'(busy));
        check("stall_cnt", 32'(stall_cnt), 32'(scnt));
        @(posedge clk);
        if (rst_n && !busy) begin
            if (v && wr && !e_stall && !e_flush)
                q.push_back('{idx: adv, a: wa, ld: ld});
            adv++;
            if (br && v && !e_stall && !e_flush) fl_left = BF;
            else if (fl_left > 0) fl_left--;
            if (e_stall && scnt < 65535) scnt++;
            while (q.size() > 0 && adv - 1 - q[0].idx >= FWD)
                void'(q.pop_front());
        end
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #2;
        check("rst_fwda", 32'(fwda), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU writer r3 then consumers at distance 1..4
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        check("alu_exe", 32'(fwda), 3);
        step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        check("alu_mem", 32'(fwda), 2);
        step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        check("alu_wb", 32'(fwda), 1);
        step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        check("alu_rf", 32'(fwda), 0);

        // load-use on rt=r5
        step(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        step(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
        check("lu_stall", 32'(stall), 1);
        step(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
        check("lu_fwdb", 32'(fwdb), 2);
        check("lu_cnt", 32'(stall_cnt), 1);

        // nearest match and r0
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        step(1, 7, 0, 1, 0, 1, 0, 0, 0, 0);
        check("near", 32'(fwda), 3);
        step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        check("r0", 32'(fwda), 0);

        // branch flush with second branch inside window
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 9, 0, 1, 0);
        check("fl1", 32'(flush), 1);
        step(1, 9, 0, 1, 0, 1, 9, 0, 0, 0);
        check("fl2", 32'(flush), 1);
        step(1, 9, 0, 1, 0, 0, 0, 0, 0, 0);
        check("fl_end", 32'(flush), 0);
        check("fl_squash", 32'(fwda), 0);

        // freeze in the middle of a load-use stall
        step(1, 0, 0, 0, 0, 1, 6, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 6, 0, 1, 0, 0, 0, 0, 0, 1);
            check("frz_hold", 32'(pc_hold), 1);
        end
        step(1, 6, 0, 1, 0, 0, 0, 0, 0, 0);
        check("frz_stall", 32'(stall), 1);
        step(1, 6, 0, 1, 0, 0, 0, 0, 0, 0);
        check("frz_fwd", 32'(fwda), 2);

        // async reset mid-stall with a load in flight
        step(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
        @(negedge clk);
        id_valid = 1; rs = 4; rs_used = 1; id_wreg = 0;
        id_load = 0; branch_taken = 0; mem_busy = 0;
        #1;
        check("pre_rst_stall", 32'(stall), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ar_stall", 32'(stall), 0);
        check("ar_fwda", 32'(fwda), 0);
        check("ar_fwdb", 32'(fwdb), 0);
        check("ar_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 4, 0, 1, 0, 0, 0, 0, 0, 0);
        check("post_rst", 32'(stall), 0);

        // random traffic on a small register set
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(7, 0) != 0,
                 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom_range(3, 0)),
                 $urandom_range(2, 0) == 0,
                 $urandom_range(7, 0) == 0,
                 $urandom_range(7, 0) == 0);
        end
        nop();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational stall/forward decoder.
- Keeps its own shift-register scoreboard of in-flight register writes across FWD_STAGES stages after ID, and generates per-operand forward selects and load-use stalls.
- Adds multi-cycle load latency, a freeze input for a busy memory, a registered multi-slot branch flush and a saturating stall counter.
- Sits beside the ID stage; the decoder supplies per-instruction register usage.

Parameters:
- REG_AW, 5, register address width.
- FWD_STAGES, 3, tracked stages after ID (index 0 = EXE, 1 = MEM, 2 = WB).
- LOAD_READY, 1, first stage index at which a load result can be forwarded (1..FWD_STAGES-1).
- BR_FLUSH, 1, fetch slots squashed after a taken branch/jump (1..7).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- rs  in  REG_AW  source A address.
- rt  in  REG_AW  source B address.
- rs_used  in  1  instruction reads rs.
- rt_used  in  1  instruction reads rt.
- id_wreg  in  1  instruction writes a register.
- id_waddr  in  REG_AW  destination address.
- id_load  in  1  instruction is a load.
- branch_taken  in  1  taken branch/jump resolved in ID.
- mem_busy  in  1  memory not ready; whole pipeline frozen.
- fwda  out  FWSEL_W  rs forward select; FWSEL_W = clog2(FWD_STAGES+1).
- fwdb  out  FWSEL_W  rt forward select.
- stall  out  1  hold ID and IF, inject bubble into EXE.
- pc_hold  out  1  PC must not advance.
- flush  out  1  squash the instruction in IF/ID.
- freeze  out  1  all pipeline registers hold.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, rst_n=0): all scoreboard entries invalid, flush counter 0, stall_cnt 0. fwda and fwdb then read 0; stall, pc_hold, flush and freeze read 0.
- Scoreboard entry k holds {valid, waddr, load}.
  - Each non-frozen cycle, entry k+1 <= entry k.
  - Entry 0 <= {id_valid & id_wreg & ~stall & ~flush, id_waddr, id_load}.
  - The entry leaving stage FWD_STAGES-1 is discarded.
- Entry k is ready if load=0, or if load=1 and k >= LOAD_READY.
- Forward select, per operand, combinational:
  - The operand is considered only when its _used bit is 1 and its address is nonzero.
  - Find the smallest k with a valid entry whose waddr matches the operand.
  - If found and ready: select = FWD_STAGES-k (EXE=3, MEM=2, WB=1 at default).
  - Otherwise select = 0 (register file).
  - Only the nearest match counts; older matches are ignored.
- Load-use stall: asserted when id_valid=1 and the nearest match of either considered operand is not ready. Repeats each cycle until the load reaches LOAD_READY. pc_hold = stall | freeze.
- While stall=1, branch_taken is ignored; a branch resolves only once its operands are available.
- freeze = mem_busy.
  - Freeze dominates: no scoreboard shift, flush counter holds, stall_cnt holds.
  - stall output is still computed but has no effect on state.
- Flush:
  - branch_taken=1 with id_valid=1, ~stall, ~freeze, ~flush loads the flush counter with BR_FLUSH.
  - flush = (counter != 0); the counter decrements on each non-frozen cycle.
  - A branch arriving while flush=1 is itself squashed and ignored.
- stall_cnt increments on each cycle with stall=1 and freeze=0, and saturates at all-ones.
- Register 0 never matches, never stalls and never forwards.

Test Plan:
- Back-to-back ALU dependency: add r3 writer, then a consumer of rs=r3 next cycle -> fwda=3 and no stall. Two cycles later -> fwda=2; three cycles later -> fwda=1; four cycles later -> fwda=0.
- Load-use, LOAD_READY=1: lw r5 followed by an rt=r5 reader -> stall=1 and pc_hold=1 for 1 cycle, bubble (invalid entry) in EXE, then fwdb=2. Rerun with LOAD_READY=2 -> 2 stall cycles, then fwdb=1; stall_cnt ends at 2.
- Nearest-match priority: writers to r7 in both EXE and MEM, consumer reads r7 -> fwda=3. Consumer reads r0 with an r0 writer in flight -> fwda=0 and no stall.
- Branch flush, BR_FLUSH=2: branch_taken pulse -> flush=1 for exactly 2 cycles; a second branch_taken during the flush window is ignored; squashed slots enter the scoreboard invalid.
- Freeze: mem_busy=1 for 3 cycles in the middle of a load-use stall -> freeze=1 and pc_hold=1; scoreboard, flush counter and stall_cnt unchanged. After release, behaviour resumes identically to the unfrozen sequence.
- Async reset mid-stall with a load in flight: rst_n=0 between clock edges -> stall=0 and fwda=fwdb=0 immediately, stall_cnt=0. After reset release, the old consumer does not stall.
